// File: rtl/slvae_4k_sp.sv
// Serial bus slave fronting a 4K x DATA_W memory: start bit, LSB-first address, then write or (splittable) read byte.
// Latency: B_ACK one cycle after last address bit; read data starts one cycle after fetch; S_DVALID one cycle after last data bit.
// Backpressure: a read is stalled in fetch while S_SPLIT=1, or parked in SPLIT until the arbiter resumes it.
module slvae_4k_sp #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 8,
    parameter int MEM_DEPTH = 4096
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              AD_SEL,
    input  logic              B_RW,
    input  logic              B_BUS_OUT,
    output logic              B_BUS_IN,
    output logic              B_ACK,
    output logic              B_SBSY,
    input  logic              S_SPLIT,
    input  logic              B_SPLIT,
    input  logic              B_SPL_RESUME,
    output logic              S_DVALID,
    output logic [DATA_W-1:0] S_DOUT
);

    localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int CNT_W = $clog2(MAX_W) + 1;
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] ADDR   = 3'd1;
    localparam logic [2:0] WDATA  = 3'd2;
    localparam logic [2:0] RFETCH = 3'd3;
    localparam logic [2:0] SPLIT  = 3'd4;
    localparam logic [2:0] RDATA  = 3'd5;
    localparam logic [2:0] DONE   = 3'd6;

    logic [2:0]        state;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] sh;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] mem [MEM_DEPTH];

    logic [IDX_W-1:0]  idx;
    logic              last_addr;
    logic              last_data;
    logic              wr_en;
    logic [DATA_W-1:0] wr_byte;
    logic [DATA_W-1:0] rd_rot;

    assign idx       = IDX_W'(32'(addr) % MEM_DEPTH);
    assign last_addr = (cnt == CNT_W'(ADDR_W - 1));
    assign last_data = (cnt == CNT_W'(DATA_W - 1));
    assign wr_byte   = {B_BUS_OUT, sh[DATA_W-1:1]};
    // Read data rotates rather than shifts so the byte is intact again for S_DOUT.
    assign rd_rot    = {sh[0], sh[DATA_W-1:1]};
    assign wr_en     = (state == WDATA) && AD_SEL && last_data;

    assign B_SBSY   = (state != IDLE);
    assign B_BUS_IN = (state == RDATA) && sh[0];
    assign S_DVALID = (state == DONE);

    // Memory has no reset so contents survive RSTN.
    always_ff @(posedge CLK) begin
        if (wr_en) mem[idx] <= wr_byte;
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state  <= IDLE;
            rw     <= 1'b0;
            addr   <= '0;
            sh     <= '0;
            cnt    <= '0;
            B_ACK  <= 1'b0;
            S_DOUT <= '0;
        end else begin
            B_ACK <= 1'b0;
            case (state)
                IDLE: begin
                    if (AD_SEL && B_BUS_OUT) begin
                        state <= ADDR;
                        rw    <= B_RW;
                        cnt   <= '0;
                    end
                end
                ADDR: begin
                    if (!AD_SEL) begin
                        state <= IDLE;
                    end else begin
                        addr <= {B_BUS_OUT, addr[ADDR_W-1:1]};
                        cnt  <= cnt + 1'b1;
                        if (last_addr) begin
                            B_ACK <= 1'b1;
                            cnt   <= '0;
                            state <= rw ? WDATA : RFETCH;
                        end
                    end
                end
                WDATA: begin
                    if (!AD_SEL) begin
                        state <= IDLE;
                    end else begin
                        sh  <= wr_byte;
                        cnt <= cnt + 1'b1;
                        if (last_data) begin
                            S_DOUT <= wr_byte;
                            state  <= DONE;
                        end
                    end
                end
                RFETCH: begin
                    sh <= mem[idx];
                    if (S_SPLIT && B_SPLIT) begin
                        state <= SPLIT;
                    end else if (!S_SPLIT) begin
                        state <= RDATA;
                        cnt   <= '0;
                    end
                end
                SPLIT: begin
                    if (B_SPL_RESUME && !S_SPLIT) begin
                        state <= RDATA;
                        cnt   <= '0;
                    end
                end
                RDATA: begin
                    sh  <= rd_rot;
                    cnt <= cnt + 1'b1;
                    if (last_data) begin
                        S_DOUT <= rd_rot;
                        state  <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_slvae_4k_sp.sv
// Directed plus randomized transactions on slvae_4k_sp, checked against an associative-array memory model.
module tb_slvae_4k_sp;
    localparam int AW    = 12;
    localparam int DW    = 8;
    localparam int DEPTH = 4096;

    logic CLK = 1'b0;
    logic RSTN = 1'b0;
    logic AD_SEL = 1'b0, B_RW = 1'b0, B_BUS_OUT = 1'b0;
    logic S_SPLIT = 1'b0, B_SPLIT = 1'b0, B_SPL_RESUME = 1'b0;
    logic B_BUS_IN, B_ACK, B_SBSY, S_DVALID;
    logic [DW-1:0] S_DOUT;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] ref_mem [int];
    int written [$];

    slvae_4k_sp #(.ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(DEPTH)) dut (
        .CLK(CLK), .RSTN(RSTN), .AD_SEL(AD_SEL), .B_RW(B_RW), .B_BUS_OUT(B_BUS_OUT),
        .B_BUS_IN(B_BUS_IN), .B_ACK(B_ACK), .B_SBSY(B_SBSY), .S_SPLIT(S_SPLIT),
        .B_SPLIT(B_SPLIT), .B_SPL_RESUME(B_SPL_RESUME), .S_DVALID(S_DVALID), .S_DOUT(S_DOUT)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    // Start bit plus address; abort_at >= 0 drops AD_SEL instead of sending that bit.
    task automatic send_hdr(input logic rw, input logic [AW-1:0] a, input int abort_at);
        AD_SEL = 1'b1; B_RW = rw; B_BUS_OUT = 1'b1;
        tick();
        for (int i = 0; i < AW; i++) begin
            if (i == abort_at) begin
                AD_SEL = 1'b0; B_BUS_OUT = 1'b0;
                tick();
                return;
            end
            B_BUS_OUT = a[i];
            check("ack_low_during_addr", B_ACK, 0);
            tick();
        end
        B_BUS_OUT = 1'b0;
        check("ack_after_last_bit", B_ACK, 1);
        check("busy_after_addr", B_SBSY, 1);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input int abort_at);
        send_hdr(1'b1, a, -1);
        for (int i = 0; i < DW; i++) begin
            if (i == abort_at) begin
                AD_SEL = 1'b0; B_BUS_OUT = 1'b0;
                tick();
                check("wdata_abort_idle", B_SBSY, 0);
                check("wdata_abort_dvalid", S_DVALID, 0);
                return;
            end
            B_BUS_OUT = d[i];
            tick();
            if (i == 0) check("ack_one_cycle", B_ACK, 0);
        end
        B_BUS_OUT = 1'b0; AD_SEL = 1'b0;
        check("wr_dvalid", S_DVALID, 1);
        check("wr_dout", S_DOUT, d);
        ref_mem[int'(a) % DEPTH] = d;
        written.push_back(int'(a));
        tick();
        check("wr_back_idle", B_SBSY, 0);
        check("wr_dvalid_pulse", S_DVALID, 0);
        check("wr_dout_hold", S_DOUT, d);
    endtask

    // mode 0: plain read, 1: split for `hold` cycles, 2: stall in fetch for `hold` cycles
    task automatic do_read(input logic [AW-1:0] a, input int mode, input int hold);
        logic [DW-1:0] want;
        want = ref_mem[int'(a) % DEPTH];
        send_hdr(1'b0, a, -1);
        AD_SEL = 1'b0;
        if (mode == 1) begin
            S_SPLIT = 1'b1; B_SPLIT = 1'b1;
            for (int h = 0; h < hold; h++) begin
                tick();
                B_SPLIT = 1'($urandom_range(0, 1));
                B_SPL_RESUME = 1'($urandom_range(0, 1));
                check("split_busy", B_SBSY, 1);
                check("split_bus_in", B_BUS_IN, 0);
            end
            S_SPLIT = 1'b0; B_SPL_RESUME = 1'b0;
            tick();
            check("split_wait_resume", B_BUS_IN, 0);
            B_SPL_RESUME = 1'b1;
            tick();
            B_SPL_RESUME = 1'b0; B_SPLIT = 1'b0;
        end else if (mode == 2) begin
            S_SPLIT = 1'b1; B_SPLIT = 1'b0;
            for (int h = 0; h < hold; h++) begin
                tick();
                check("stall_busy", B_SBSY, 1);
                check("stall_bus_in", B_BUS_IN, 0);
                check("stall_dvalid", S_DVALID, 0);
            end
            S_SPLIT = 1'b0;
            tick();
        end else begin
            tick();
        end
        for (int i = 0; i < DW; i++) begin
            check($sformatf("rd_bit%0d", i), B_BUS_IN, want[i]);
            tick();
        end
        check("rd_dvalid", S_DVALID, 1);
        check("rd_dout", S_DOUT, want);
        tick();
        check("rd_back_idle", B_SBSY, 0);
        check("rd_bus_in_idle", B_BUS_IN, 0);
    endtask

    initial begin
        logic [DW-1:0] pat;
        tick();
        tick();
        check("rst_bus_in", B_BUS_IN, 0);
        check("rst_ack", B_ACK, 0);
        check("rst_busy", B_SBSY, 0);
        check("rst_dvalid", S_DVALID, 0);
        check("rst_dout", S_DOUT, 0);
        RSTN = 1'b1;
        tick();

        // Bus line high without select must not start a transaction.
        B_BUS_OUT = 1'b1;
        tick();
        tick();
        check("no_start_unselected", B_SBSY, 0);
        B_BUS_OUT = 1'b0;
        tick();

        do_write(12'h001, 8'hA5, -1);
        do_read(12'h001, 0, 0);
        pat = 8'hA5;
        check("readback_pattern", {24'd0, ref_mem[1]}, {24'd0, pat});
        do_read(12'h001, 1, 3);
        do_read(12'h001, 2, 4);

        send_hdr(1'b1, 12'h7F3, 5);
        check("addr_abort_idle", B_SBSY, 0);
        check("addr_abort_dout_hold", S_DOUT, 8'hA5);
        tick();

        do_write(12'h001, 8'h3C, 4);
        tick();
        do_read(12'h001, 0, 0);

        // Reset in the middle of shifting read data out.
        send_hdr(1'b0, 12'h001, -1);
        AD_SEL = 1'b0;
        tick();
        tick();
        tick();
        #2 RSTN = 1'b0;
        #1;
        check("rstmid_bus_in", B_BUS_IN, 0);
        check("rstmid_ack", B_ACK, 0);
        check("rstmid_busy", B_SBSY, 0);
        check("rstmid_dvalid", S_DVALID, 0);
        check("rstmid_dout", S_DOUT, 0);
        tick();
        RSTN = 1'b1;
        tick();
        do_read(12'h001, 0, 0);

        for (int n = 0; n < 30; n++) begin
            if (written.size() < 3 || $urandom_range(0, 1) == 0) begin
                do_write(AW'($urandom_range(0, DEPTH - 1)), DW'($urandom), -1);
            end else begin
                do_read(AW'(written[$urandom_range(0, written.size() - 1)]),
                        int'($urandom_range(0, 2)), int'($urandom_range(1, 4)));
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
